// File: rtl/uart_tx_ctrl_if.sv
// Handshake and control bundle between the TX buffer, the UART TX controller
// and the external shift register / line mux.
interface uart_tx_ctrl_if;
    logic       tx_valid;
    logic       tx_abort;
    logic       tx_ready;
    logic       load_shift;
    logic       shift_enable;
    logic [1:0] tx_sel;
    logic       tx_busy;
    logic       tx_done;

    // TX buffer / frame owner side
    modport master (
        output tx_valid,
        output tx_abort,
        input  tx_ready,
        input  load_shift,
        input  shift_enable,
        input  tx_sel,
        input  tx_busy,
        input  tx_done
    );

    // Controller side
    modport slave (
        input  tx_valid,
        input  tx_abort,
        output tx_ready,
        output load_shift,
        output shift_enable,
        output tx_sel,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: walks start, data, optional parity and stop bits,
// timing each bit with its own counter. Holds no data itself.
module uart_tx_ctrl #(
    parameter int BIT_PERIOD = 10,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_ctrl_if.slave bus
);
    localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int CW = $clog2(DATA_BITS + 2);

    localparam logic [1:0] SEL_IDLE   = 2'b00;
    localparam logic [1:0] SEL_START  = 2'b01;
    localparam logic [1:0] SEL_SHIFT  = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [TW-1:0]  timer;
    logic [CW-1:0]  bit_cnt;
    logic           done_q;
    logic           tick;
    logic           timing;
    logic           last_data;
    logic           last_stop;
    logic           abort_now;

    assign tick      = (timer == TW'(BIT_PERIOD - 1));
    assign last_data = (bit_cnt == CW'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == CW'(STOP_BITS - 1));
    assign timing    = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);
    assign abort_now = bus.tx_abort && (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; unknown encodings fall back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.tx_valid) state_nxt = LOAD;
            LOAD:    state_nxt = START;
            START:   if (tick) state_nxt = DATA;
            DATA:    if (tick && last_data) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (tick) state_nxt = STOP;
            STOP:    if (tick && last_stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_now) state_nxt = IDLE;
    end

    // Bit timer and bit counter; the counter is reused for data and stop bits
    always_ff @(posedge clk) begin
        if (rst || abort_now) begin
            timer   <= '0;
            bit_cnt <= '0;
        end else begin
            timer <= (timing && !tick) ? timer + TW'(1) : '0;
            case (state)
                DATA:    if (tick) bit_cnt <= last_data ? '0 : bit_cnt + CW'(1);
                STOP:    if (tick) bit_cnt <= last_stop ? '0 : bit_cnt + CW'(1);
                default: bit_cnt <= '0;
            endcase
        end
    end

    // Completion pulse lands in the first IDLE cycle after the last stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == STOP) && tick && last_stop && !bus.tx_abort;
        end
    end

    // Output decode from state and registered counters
    always_comb begin
        bus.tx_ready     = 1'b0;
        bus.load_shift   = 1'b0;
        bus.shift_enable = 1'b0;
        bus.tx_sel       = SEL_IDLE;
        bus.tx_busy      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    bus.tx_ready = 1'b1;
                end
                LOAD: begin
                    bus.load_shift = 1'b1;
                    bus.tx_busy    = 1'b1;
                end
                START: begin
                    bus.tx_sel  = SEL_START;
                    bus.tx_busy = 1'b1;
                end
                DATA: begin
                    bus.tx_sel       = SEL_SHIFT;
                    bus.tx_busy      = 1'b1;
                    bus.shift_enable = tick && !bus.tx_abort;
                end
                PARITY: begin
                    bus.tx_sel  = SEL_PARITY;
                    bus.tx_busy = 1'b1;
                end
                STOP: begin
                    bus.tx_busy = 1'b1;
                end
                default: begin
                    bus.tx_ready = 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: two instances (plain 8N1 and 8 data +
// parity + 2 stop), BIT_PERIOD=4, checking a packed output vector per cycle.
module tb_uart_tx_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl_if bus1();
    uart_tx_ctrl_if bus2();

    uart_tx_ctrl #(.BIT_PERIOD(4), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    uart_tx_ctrl #(.BIT_PERIOD(4), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // {tx_ready, load_shift, shift_enable, tx_sel[1:0], tx_busy, tx_done}
    logic [6:0] obs1, obs2;
    assign obs1 = {bus1.tx_ready, bus1.load_shift, bus1.shift_enable, bus1.tx_sel, bus1.tx_busy, bus1.tx_done};
    assign obs2 = {bus2.tx_ready, bus2.load_shift, bus2.shift_enable, bus2.tx_sel, bus2.tx_busy, bus2.tx_done};

    localparam logic [6:0] V_RST   = 7'b0000000;
    localparam logic [6:0] V_IDLE  = 7'b1000000;
    localparam logic [6:0] V_DONE  = 7'b1000001;
    localparam logic [6:0] V_LOAD  = 7'b0100010;
    localparam logic [6:0] V_START = 7'b0000110;
    localparam logic [6:0] V_DATA  = 7'b0001010;
    localparam logic [6:0] V_SHIFT = 7'b0011010;
    localparam logic [6:0] V_PAR   = 7'b0001110;
    localparam logic [6:0] V_STOP  = 7'b0000010;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected outputs k cycles after the accept cycle (BIT_PERIOD=4, 8 data bits)
    function automatic logic [6:0] exp_vec(input int k, input int p, input int s,
                                           input bit first_done, input int abort_k,
                                           input int rst_k);
        int end_c;
        logic [6:0] v;
        end_c = 2 + 4 * (1 + 8 + p + s);
        if (rst_k >= 0 && k >= rst_k) return (k <= rst_k + 1) ? V_RST : V_IDLE;
        if (abort_k >= 0 && k > abort_k) return V_IDLE;
        if (k == 0)                   v = first_done ? V_DONE : V_IDLE;
        else if (k == 1)              v = V_LOAD;
        else if (k <= 5)              v = V_START;
        else if (k <= 37)             v = (((k - 6) % 4) == 3) ? V_SHIFT : V_DATA;
        else if (p != 0 && k <= 41)   v = V_PAR;
        else if (k < end_c)           v = V_STOP;
        else if (k == end_c)          v = V_DONE;
        else                          v = V_IDLE;
        if (k == abort_k) v[4] = 1'b0;
        return v;
    endfunction

    task automatic run_frame(input int dut, input int p, input int s, input bit first_done,
                             input bit adv0, input bit drop_valid, input int last_k,
                             input int abort_k, input int rst_k);
        logic [6:0] obs;
        for (int k = 0; k <= last_k; k++) begin
            if (k > 0 || adv0) begin
                @(posedge clk);
                #1;
            end
            if (k == 0) begin
                if (dut == 0) bus1.tx_valid = 1'b1; else bus2.tx_valid = 1'b1;
            end
            if (k == 1 && drop_valid) begin
                if (dut == 0) bus1.tx_valid = 1'b0; else bus2.tx_valid = 1'b0;
            end
            if (dut == 0) bus1.tx_abort = (k == abort_k); else bus2.tx_abort = (k == abort_k);
            if (rst_k >= 0 && k == rst_k)     rst = 1'b1;
            if (rst_k >= 0 && k == rst_k + 2) rst = 1'b0;
            #1;
            obs = (dut == 0) ? obs1 : obs2;
            chk($sformatf("dut%0d_k%0d", dut, k), obs,
                exp_vec(k, p, s, first_done, abort_k, rst_k));
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus1.tx_valid = 1'b1;
        bus1.tx_abort = 1'b0;
        bus2.tx_valid = 1'b0;
        bus2.tx_abort = 1'b0;

        // Reset dominates a pending tx_valid
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            chk($sformatf("reset_%0d", i), obs1, V_RST);
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus1.tx_valid = 1'b0;
        #1;
        chk("post_reset_dut1", obs1, V_IDLE);
        chk("post_reset_dut2", obs2, V_IDLE);

        // Single frame, done pulse only at 42
        run_frame(0, 0, 1, 1'b0, 1'b1, 1'b1, 44, -1, -1);

        // Back-to-back: second accept in the done cycle
        run_frame(0, 0, 1, 1'b0, 1'b1, 1'b0, 42, -1, -1);
        run_frame(0, 0, 1, 1'b1, 1'b0, 1'b1, 44, -1, -1);

        // Parity with two stop bits
        run_frame(1, 1, 2, 1'b0, 1'b1, 1'b1, 52, -1, -1);

        // Abort on a DATA tick cycle: no shift, no done
        run_frame(0, 0, 1, 1'b0, 1'b1, 1'b1, 46, 21, -1);

        // Mid-frame reset, then a clean full frame
        run_frame(0, 0, 1, 1'b0, 1'b1, 1'b1, 12, -1, 7);
        run_frame(0, 0, 1, 1'b0, 1'b1, 1'b1, 44, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
